// File: rtl/rx_link_monitor_pkg.sv
// Shared types, control-bit indices, counter widths and helpers for the rx link monitor.
package rx_link_mon_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } lm_state_e;

    // Bit positions inside the VIO control word
    localparam int CTRL_CLR = 0;
    localparam int CTRL_EN  = 1;

    localparam int WORD_CNT_W    = 48;
    localparam int ERR_CNT_W     = 32;
    localparam int BIT_ERR_CNT_W = 48;
    localparam int LOST_CNT_W    = 8;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + {5'b0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/rx_link_monitor_if.sv
// Lane-side and debug-core-side signals of one rx link monitor instance.
interface rx_link_monitor_if;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic [31:0] vio_ctrl;
    logic [31:0] vio_status;
    logic [47:0] ila_data;
    logic [47:0] ila_err;
    logic [47:0] ila_cnt;

    modport master (
        output rx_data, rx_valid, vio_ctrl,
        input  vio_status, ila_data, ila_err, ila_cnt
    );

    modport slave (
        input  rx_data, rx_valid, vio_ctrl,
        output vio_status, ila_data, ila_err, ila_cnt
    );
endinterface

// File: rtl/rx_link_monitor_ctrl_sync.sv
// Two-flop synchronizer with rising-edge detect for quasi-static VIO control bits.
module rx_link_ctrl_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] rise
);
    logic [W-1:0] meta;
    logic [W-1:0] sync;
    logic [W-1:0] sync_d;

    // Metastability chain plus one history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= '0;
            sync   <= '0;
            sync_d <= '0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign sync_out = sync;
    assign rise     = sync & ~sync_d;
endmodule

// File: rtl/rx_link_monitor.sv
// Per-lane incrementing-pattern checker: lock tracking, error counters, ILA/VIO probes.
module rx_link_monitor
    import rx_link_mon_pkg::*;
#(
    parameter int          LOCK_CNT    = 8,
    parameter int          UNLOCK_ERRS = 4,
    parameter logic [31:0] PAT_INC     = 32'd1
) (
    input  logic              rxclk,
    input  logic              rst,
    rx_link_monitor_if.slave  lnk
);
    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_ERRS - 1);

    logic [1:0] ctrl_sync, ctrl_rise;
    logic       en, clr_pulse;

    rx_link_ctrl_sync #(.W(2)) u_ctrl_sync (
        .clk      (rxclk),
        .rst      (rst),
        .async_in (lnk.vio_ctrl[1:0]),
        .sync_out (ctrl_sync),
        .rise     (ctrl_rise)
    );

    assign en        = ctrl_sync[CTRL_EN];
    assign clr_pulse = ctrl_rise[CTRL_CLR];

    // Control bits with no function here are deliberately dropped
    logic unused_ctrl;
    assign unused_ctrl = ^{lnk.vio_ctrl[31:2], ctrl_sync[CTRL_CLR], ctrl_rise[CTRL_EN]};

    logic [31:0] d1;
    logic        v1;

    // Stage 1: capture the recovered word
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            d1 <= lnk.rx_data;
            v1 <= lnk.rx_valid;
        end
    end

    lm_state_e                  state, state_nx;
    logic [31:0]                exp_word, exp_nx;
    logic [7:0]                 good, good_nx;
    logic [7:0]                 bad_run, bad_nx;
    logic [WORD_CNT_W-1:0]      word_cnt, word_nx;
    logic [ERR_CNT_W-1:0]       err_cnt, err_nx;
    logic [BIT_ERR_CNT_W-1:0]   bit_err_cnt, bit_err_nx;
    logic [LOST_CNT_W-1:0]      lost_cnt, lost_nx;
    logic [BIT_ERR_CNT_W:0]     bits_sum;
    logic                       word_inc, err_inc, lost_inc;
    logic                       mis;
    logic [31:0]                diff;
    logic [31:0]                vio_status_q, vio_status_nx;
    logic [47:0]                ila_data_q, ila_data_nx;
    logic [47:0]                ila_err_q, ila_err_nx;

    assign diff = d1 ^ exp_word;
    assign mis  = v1 & (d1 != exp_word);

    // Lock state register
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) state <= HUNT;
        else     state <= state_nx;
    end

    // Lock transitions; only valid words move the machine, disable overrides all
    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = HUNT;
        end else if (v1) begin
            case (state)
                HUNT:    state_nx = ALIGN;
                ALIGN:   if (!mis && good == LOCK_LAST) state_nx = LOCKED;
                LOCKED:  if (mis && bad_run == UNLOCK_LAST) state_nx = HUNT;
                default: state_nx = HUNT;
            endcase
        end
    end

    // Pattern tracking, counter updates and next probe values
    always_comb begin
        exp_nx   = exp_word;
        good_nx  = good;
        bad_nx   = bad_run;
        word_inc = 1'b0;
        err_inc  = 1'b0;
        lost_inc = 1'b0;
        if (en && v1) begin
            case (state)
                HUNT: begin
                    exp_nx  = d1 + PAT_INC;
                    good_nx = '0;
                end
                ALIGN: begin
                    if (mis) begin
                        exp_nx  = d1 + PAT_INC;
                        good_nx = '0;
                    end else begin
                        exp_nx  = exp_word + PAT_INC;
                        good_nx = good + 8'd1;
                        if (good == LOCK_LAST) bad_nx = '0;
                    end
                end
                LOCKED: begin
                    // Once locked the expected value free-runs; no resync on errors
                    word_inc = 1'b1;
                    exp_nx   = exp_word + PAT_INC;
                    if (mis) begin
                        err_inc  = 1'b1;
                        bad_nx   = bad_run + 8'd1;
                        lost_inc = (bad_run == UNLOCK_LAST);
                    end else begin
                        bad_nx = '0;
                    end
                end
                default: ;
            endcase
        end

        bits_sum = {1'b0, bit_err_cnt} + {{(BIT_ERR_CNT_W-5){1'b0}}, popcount32(diff)};

        // Saturating counters; clear takes priority over any same-cycle increment
        word_nx    = (word_inc && !(&word_cnt)) ? word_cnt + 1'b1 : word_cnt;
        err_nx     = (err_inc  && !(&err_cnt))  ? err_cnt  + 1'b1 : err_cnt;
        lost_nx    = (lost_inc && !(&lost_cnt)) ? lost_cnt + 1'b1 : lost_cnt;
        bit_err_nx = !err_inc ? bit_err_cnt :
                     bits_sum[BIT_ERR_CNT_W] ? {BIT_ERR_CNT_W{1'b1}} :
                     bits_sum[BIT_ERR_CNT_W-1:0];
        if (clr_pulse) begin
            word_nx    = '0;
            err_nx     = '0;
            lost_nx    = '0;
            bit_err_nx = '0;
        end

        ila_data_nx   = {state_nx, v1, mis, 12'b0, d1};
        ila_err_nx    = {err_nx[15:0], mis ? diff : 32'b0};
        vio_status_nx = {state_nx, en, 5'b0, lost_nx, err_nx[15:0]};
    end

    // Stage 2: datapath, counters and registered probes
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            exp_word     <= '0;
            good         <= '0;
            bad_run      <= '0;
            word_cnt     <= '0;
            err_cnt      <= '0;
            bit_err_cnt  <= '0;
            lost_cnt     <= '0;
            ila_data_q   <= '0;
            ila_err_q    <= '0;
            vio_status_q <= '0;
        end else begin
            exp_word     <= exp_nx;
            good         <= good_nx;
            bad_run      <= bad_nx;
            word_cnt     <= word_nx;
            err_cnt      <= err_nx;
            bit_err_cnt  <= bit_err_nx;
            lost_cnt     <= lost_nx;
            ila_data_q   <= ila_data_nx;
            ila_err_q    <= ila_err_nx;
            vio_status_q <= vio_status_nx;
        end
    end

    assign lnk.ila_data   = ila_data_q;
    assign lnk.ila_err    = ila_err_q;
    assign lnk.ila_cnt    = word_cnt;
    assign lnk.vio_status = vio_status_q;
endmodule

// File: tb/tb_rx_link_monitor.sv
// Randomized bench for rx_link_monitor against a cycle-level behavioural model.
module tb_rx_link_monitor;
    localparam int    LOCK_CNT    = 8;
    localparam int    UNLOCK_ERRS = 4;
    localparam longint MAX48      = 64'h0000_FFFF_FFFF_FFFF;
    localparam longint MAX32      = 64'h0000_0000_FFFF_FFFF;

    logic rxclk;
    logic rst;
    rx_link_monitor_if lnk();

    rx_link_monitor #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERRS(UNLOCK_ERRS), .PAT_INC(32'd1)) dut (
        .rxclk (rxclk),
        .rst   (rst),
        .lnk   (lnk.slave)
    );

    initial rxclk = 1'b0;
    always #5 rxclk = ~rxclk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    // Behavioural model: lock state as a small integer, counters as plain integers
    int          m_st, m_good, m_bad;
    logic [31:0] m_exp;
    longint      m_word, m_err, m_bits, m_lost;
    logic [31:0] h_d1;
    logic        h_v1;
    logic [1:0]  h_c1, h_c2, h_c3;
    logic [47:0] e_data, e_err, e_cnt, e_stat;

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_zero();
        m_st = 0; m_good = 0; m_bad = 0; m_exp = '0;
        m_word = 0; m_err = 0; m_bits = 0; m_lost = 0;
        h_d1 = '0; h_v1 = 1'b0; h_c1 = '0; h_c2 = '0; h_c3 = '0;
    endtask

    task automatic model_step(input logic [31:0] nd, input logic nv, input logic [1:0] nc);
        logic        en, clr, mis;
        logic [31:0] diff;
        logic [1:0]  st2;
        logic [15:0] err16;
        logic [7:0]  lost8;
        en   = h_c2[1];
        clr  = h_c2[0] && !h_c3[0];
        mis  = h_v1 && (h_d1 != m_exp);
        diff = h_d1 ^ m_exp;
        if (!en) begin
            m_st = 0;
        end else if (h_v1) begin
            if (m_st == 2) begin
                m_word = sat(m_word + 1, MAX48);
                m_exp  = m_exp + 32'd1;
                if (mis) begin
                    m_err  = sat(m_err + 1, MAX32);
                    m_bits = sat(m_bits + $countones(diff), MAX48);
                    m_bad++;
                    if (m_bad == UNLOCK_ERRS) begin
                        m_st   = 0;
                        m_lost = sat(m_lost + 1, 255);
                    end
                end else begin
                    m_bad = 0;
                end
            end else if (m_st == 1 && !mis) begin
                m_exp = m_exp + 32'd1;
                m_good++;
                if (m_good == LOCK_CNT) begin
                    m_st  = 2;
                    m_bad = 0;
                end
            end else begin
                m_st   = 1;
                m_exp  = h_d1 + 32'd1;
                m_good = 0;
            end
        end
        if (clr) begin
            m_word = 0; m_err = 0; m_bits = 0; m_lost = 0;
        end
        st2    = 2'(m_st);
        err16  = 16'(m_err);
        lost8  = 8'(m_lost);
        e_data = {st2, h_v1, mis, 12'b0, h_d1};
        e_err  = {err16, mis ? diff : 32'b0};
        e_cnt  = 48'(m_word);
        e_stat = {16'b0, st2, en, 5'b0, lost8, err16};
        h_c3 = h_c2; h_c2 = h_c1; h_c1 = nc;
        h_d1 = nd;   h_v1 = nv;
    endtask

    logic [1:0]  g_ctrl;
    logic [31:0] nxt;

    task automatic cycle(input logic [31:0] d, input logic v);
        logic [29:0] junk;
        junk         = 30'($urandom);
        lnk.rx_data  = d;
        lnk.rx_valid = v;
        lnk.vio_ctrl = {junk, g_ctrl};
        @(posedge rxclk);
        #1;
        model_step(d, v, g_ctrl);
        chk("ila_data",   lnk.ila_data,            e_data);
        chk("ila_err",    lnk.ila_err,             e_err);
        chk("ila_cnt",    lnk.ila_cnt,             e_cnt);
        chk("vio_status", {16'b0, lnk.vio_status}, e_stat);
    endtask

    task automatic send(input logic [31:0] d);
        cycle(d, 1'b1);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) cycle($urandom, 1'b0);
    endtask

    task automatic good_words(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) gap($urandom_range(1, 5));
            send(nxt);
            nxt = nxt + 32'd1;
        end
    endtask

    task automatic bad_word(input logic [31:0] mask);
        send(nxt ^ mask);
        nxt = nxt + 32'd1;
    endtask

    // Reset asserted away from the clock edge; outputs must clear without an edge
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_ila_data",   lnk.ila_data,            48'd0);
        chk("rst_ila_err",    lnk.ila_err,             48'd0);
        chk("rst_ila_cnt",    lnk.ila_cnt,             48'd0);
        chk("rst_vio_status", {16'b0, lnk.vio_status}, 48'd0);
        @(posedge rxclk);
        #3 rst = 1'b0;
        model_zero();
    endtask

    initial begin
        rst = 1'b1;
        g_ctrl = 2'b10;
        lnk.rx_data = '0; lnk.rx_valid = 1'b0; lnk.vio_ctrl = 32'h2;
        model_zero();
        repeat (2) @(posedge rxclk);
        #1;
        chk("init_vio_status", {16'b0, lnk.vio_status}, 48'd0);
        chk("init_ila_cnt",    lnk.ila_cnt,             48'd0);
        #2 rst = 1'b0;

        // Acquire lock on 0x10, 0x11, ...
        gap(3);
        nxt = 32'h10;
        good_words(LOCK_CNT, 1'b0);
        gap(2);
        chk("align_before_lock", 48'(lnk.vio_status[31:30]), 48'd1);
        good_words(1, 1'b0);
        gap(2);
        chk("locked", 48'(lnk.vio_status[31:30]), 48'd2);
        chk("cnt_at_lock", lnk.ila_cnt, 48'd0);
        good_words(3, 1'b0);
        gap(2);
        chk("cnt_post_lock", lnk.ila_cnt, 48'd3);
        chk("err_zero", 48'(lnk.vio_status[15:0]), 48'd0);

        // Single bit error, expected value keeps advancing
        bad_word(32'h0000_0001);
        good_words(1, 1'b0);
        chk("err_diff", 48'(lnk.ila_err[31:0]), 48'h1);
        chk("err_cnt1", 48'(lnk.ila_err[47:32]), 48'd1);
        good_words(1, 1'b0);
        chk("err_diff_clr", 48'(lnk.ila_err[31:0]), 48'h0);
        chk("still_locked", 48'(lnk.vio_status[31:30]), 48'd2);

        // UNLOCK_ERRS consecutive errors drop the lock
        for (int i = 0; i < UNLOCK_ERRS; i++) bad_word(32'h0000_00FF);
        gap(2);
        chk("unlock_hunt", 48'(lnk.vio_status[31:30]), 48'd0);
        chk("lost_cnt",    48'(lnk.vio_status[23:16]), 48'd1);
        chk("err_cnt5",    48'(lnk.vio_status[15:0]),  48'd5);
        good_words(1, 1'b0);
        gap(1);
        chk("restart_align", 48'(lnk.vio_status[31:30]), 48'd1);

        // Relock just below the wrap and cross it with valid gaps
        nxt = 32'hFFFF_FFF0;
        good_words(24, 1'b1);
        gap(2);
        chk("wrap_locked", 48'(lnk.vio_status[31:30]), 48'd2);
        chk("wrap_no_err", 48'(lnk.vio_status[15:0]),  48'd5);

        // Clear rising edge meets a mismatch in stage 2
        g_ctrl = 2'b11;
        good_words(1, 1'b0);
        bad_word(32'h0000_0004);
        good_words(1, 1'b0);
        gap(2);
        chk("clr_err",  48'(lnk.vio_status[15:0]),  48'd0);
        chk("clr_lost", 48'(lnk.vio_status[23:16]), 48'd0);
        chk("clr_cnt",  lnk.ila_cnt,                48'd1);
        bad_word(32'h8000_0000);
        gap(2);
        chk("clr_held_no_reclear", 48'(lnk.vio_status[15:0]), 48'd1);
        g_ctrl = 2'b10;

        // Asynchronous reset mid-lock, then full relock
        do_reset();
        gap(3);
        nxt = $urandom;
        good_words(LOCK_CNT, 1'b0);
        gap(1);
        chk("relock_not_yet", 48'(lnk.vio_status[31:30]), 48'd1);
        good_words(1, 1'b0);
        gap(1);
        chk("relock", 48'(lnk.vio_status[31:30]), 48'd2);

        // Disable mid-lock: back to HUNT, counters frozen
        g_ctrl = 2'b00;
        gap(1);
        bad_word(32'h0000_0010);
        good_words(2, 1'b0);
        gap(2);
        chk("dis_hunt", 48'(lnk.vio_status[31:30]), 48'd0);
        chk("dis_err",  48'(lnk.vio_status[15:0]),  48'd0);
        chk("dis_cnt",  lnk.ila_cnt,                48'd0);
        g_ctrl = 2'b10;
        gap(2);

        // Random traffic: gaps, errors, resyncs, clears and disables
        for (int i = 0; i < 800; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3)       g_ctrl[0] = ~g_ctrl[0];
            else if (r < 5)  g_ctrl[1] = ~g_ctrl[1];
            else if (r < 6)  nxt = $urandom;
            if (!g_ctrl[1] && $urandom_range(0, 9) == 0) g_ctrl[1] = 1'b1;
            r = int'($urandom_range(0, 99));
            if (r < 25)      gap(1);
            else if (r < 33) bad_word(32'(1) << $urandom_range(0, 31) | ($urandom & 32'h0101_0000));
            else             good_words(1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
